// File: rtl/branch_ctrl_pkg.sv
// Shared CPU branch definitions: branch-type codes, resolver FSM states and the operand-need rule.
// Types only; it holds no timing and no flow control.
package branch_ctrl_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5
  } br_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } br_state_e;

  // Only the two-register compares depend on rt; every other type tests rs against zero.
  function automatic logic br_needs_b(input logic [2:0] t);
    return (t == BR_BEQ) || (t == BR_BNE);
  endfunction

endpackage

// File: rtl/branch_ctrl_cmp.sv
// Signed 32-bit magnitude comparator (combinational, zero latency).
// Purely combinational, so it applies no backpressure.
module branch_ctrl_cmp (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        larger,
  output logic        equal,
  output logic        smaller
);

  assign equal   = (a == b);
  assign larger  = ($signed(a) > $signed(b));
  assign smaller = ($signed(a) < $signed(b));

endmodule

// File: rtl/branch_ctrl.sv
// D-stage branch resolver: redirect is registered one cycle after operands are ready.
// Holds F/D through stall_d while a needed forwarded operand is missing; flush cancels the branch.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             br_valid,
  input  logic [2:0]       br_type,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic [31:0]      pc_d,
  input  logic [15:0]      imm16,
  input  logic             flush,
  output logic             stall_d,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] resolved_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             timeout
);

  localparam int SC_W = $clog2(WAIT_MAX + 2);
  localparam logic [SC_W-1:0] SC_LIM = SC_W'(WAIT_MAX);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(WAIT_MAX + 1);

  br_state_e       state;
  logic [SC_W-1:0] stall_cnt;
  logic            need_b, ops_ready, live, resolve, taken;
  logic            larger, equal, smaller;
  logic [31:0]     cmp_b, target;

  assign need_b    = br_needs_b(br_type);
  assign ops_ready = a_ready && (b_ready || !need_b);
  // The delay-slot cycle (DONE) never stalls and never resolves.
  assign live      = br_valid && (state != ST_DONE);
  assign stall_d   = reset_n && live && !ops_ready;
  assign resolve   = live && ops_ready && !flush;
  assign cmp_b     = need_b ? rt_val : 32'd0;
  assign target    = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};

  branch_ctrl_cmp u_cmp (
    .a       (rs_val),
    .b       (cmp_b),
    .larger  (larger),
    .equal   (equal),
    .smaller (smaller)
  );

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_BEQ:  taken = equal;
      BR_BNE:  taken = !equal;
      BR_BLEZ: taken = smaller || equal;
      BR_BGTZ: taken = larger;
      BR_BLTZ: taken = smaller;
      BR_BGEZ: taken = larger || equal;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      stall_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      resolved_cnt   <= '0;
      taken_cnt      <= '0;
      timeout        <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      if (flush) begin
        state     <= ST_IDLE;
        stall_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (br_valid && ops_ready) begin
              state <= ST_DONE;
            end else if (br_valid) begin
              state     <= ST_WAIT;
              stall_cnt <= '0;
            end
          end
          ST_WAIT: begin
            if (!br_valid) begin
              state <= ST_IDLE;
            end else if (ops_ready) begin
              state <= ST_DONE;
            end else begin
              // Saturate one past the limit so a very long stall cannot wrap back under it.
              if (stall_cnt != SC_MAX) stall_cnt <= stall_cnt + 1'b1;
              if (stall_cnt >= SC_LIM) timeout <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
        if (resolve) begin
          redirect_valid <= taken;
          redirect_pc    <= target;
          resolved_cnt   <= resolved_cnt + 1'b1;
          if (taken) taken_cnt <= taken_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios followed by random traffic against a branch-pending model.
module tb_branch_ctrl;

  localparam int CW = 4;
  localparam int WM = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          br_valid;
  logic [2:0]    br_type;
  logic          a_ready, b_ready, flush;
  logic [31:0]   rs_val, rt_val, pc_d;
  logic [15:0]   imm16;
  logic          stall_d, redirect_valid, timeout;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] resolved_cnt, taken_cnt;

  int n_chk = 0;
  int n_err = 0;
  int stalls;
  bit last_stall;

  // Model: is the DUT sitting in a delay slot, is a stalled branch pending, how long has it waited.
  bit            m_slot, m_waiting, m_to, m_rv;
  int            m_wstalls;
  logic [31:0]   m_rpc;
  logic [CW-1:0] m_res, m_tak;

  always #5 clk = ~clk;

  branch_ctrl #(.CNT_W(CW), .WAIT_MAX(WM)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .br_valid       (br_valid),
    .br_type        (br_type),
    .a_ready        (a_ready),
    .b_ready        (b_ready),
    .rs_val         (rs_val),
    .rt_val         (rt_val),
    .pc_d           (pc_d),
    .imm16          (imm16),
    .flush          (flush),
    .stall_d        (stall_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .resolved_cnt   (resolved_cnt),
    .taken_cnt      (taken_cnt),
    .timeout        (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt);
    int s, r;
    s = int'(rs);
    r = int'(rt);
    case (t)
      3'd0:    return s == r;
      3'd1:    return s != r;
      3'd2:    return s <= 0;
      3'd3:    return s > 0;
      3'd4:    return s < 0;
      3'd5:    return s >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] imm);
    int off;
    off = int'($signed(imm)) * 4;
    return pc + 32'd4 + 32'(off);
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic model_reset();
    m_slot = 0; m_waiting = 0; m_to = 0; m_rv = 0;
    m_wstalls = 0; m_rpc = 32'd0; m_res = '0; m_tak = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit live, rdy;
    live = br_valid && !m_slot;
    rdy  = a_ready && (b_ready || !(br_type == 3'd0 || br_type == 3'd1));
    m_rv = 0;
    if (flush) begin
      m_slot = 0; m_waiting = 0; m_wstalls = 0;
    end else if (live && rdy) begin
      m_rv  = ref_taken(br_type, rs_val, rt_val);
      m_rpc = ref_target(pc_d, imm16);
      m_res = m_res + 1'b1;
      if (m_rv) m_tak = m_tak + 1'b1;
      m_slot = 1; m_waiting = 0;
    end else if (live) begin
      if (m_waiting) begin
        m_wstalls++;
        if (m_wstalls > WM) m_to = 1;
      end else begin
        m_waiting = 1;
        m_wstalls = 0;
      end
      m_slot = 0;
    end else begin
      m_slot = 0; m_waiting = 0;
    end
  endtask

  task automatic drv(input bit v, input logic [2:0] t, input bit ar, input bit br,
                     input logic [31:0] rs, input logic [31:0] rt,
                     input logic [31:0] pc, input logic [15:0] imm, input bit fl);
    br_valid = v; br_type = t; a_ready = ar; b_ready = br;
    rs_val = rs; rt_val = rt; pc_d = pc; imm16 = imm; flush = fl;
  endtask

  task automatic idle();
    drv(0, 3'd0, 0, 0, 32'd0, 32'd0, 32'd0, 16'd0, 0);
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic cycle();
    bit exp_stall;
    @(negedge clk);
    exp_stall  = br_valid && !m_slot &&
                 !(a_ready && (b_ready || !(br_type == 3'd0 || br_type == 3'd1)));
    last_stall = stall_d;
    chk("stall_d", 32'(stall_d), 32'(exp_stall));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    chk("resolved_cnt", 32'(resolved_cnt), 32'(m_res));
    chk("taken_cnt", 32'(taken_cnt), 32'(m_tak));
    chk("timeout", 32'(timeout), 32'(m_to));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_state_rv", 32'(redirect_valid), 32'd0);
    chk("rst_state_pc", redirect_pc, 32'd0);
    chk("rst_state_cnt", 32'({resolved_cnt, taken_cnt}), 32'd0);
    chk("rst_state_to", 32'(timeout), 32'd0);
    chk("rst_stall", 32'(stall_d), 32'd0);
    model_reset();
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drv(1, 3'd0, 0, 0, 32'd0, 32'd1, 32'd0, 16'd0, 0);
    model_reset();
    #3;
    chk("init_stall", 32'(stall_d), 32'd0);
    chk("init_rv", 32'(redirect_valid), 32'd0);
    chk("init_pc", redirect_pc, 32'd0);
    chk("init_cnt", 32'({resolved_cnt, taken_cnt}), 32'd0);
    chk("init_to", 32'(timeout), 32'd0);
    @(posedge clk); #1;
    idle();
    reset_n = 1'b1;
    cycle();

    // BEQ taken, immediate resolve.
    drv(1, 3'd0, 1, 1, 32'd5, 32'd5, 32'h3000, 16'h0004, 0);
    cycle();
    chk("beq_rv", 32'(redirect_valid), 32'd1);
    chk("beq_pc", redirect_pc, 32'h3014);
    chk("beq_taken", 32'(taken_cnt), 32'd1);
    idle(); cycle();
    chk("beq_pulse", 32'(redirect_valid), 32'd0);

    // BGTZ on a negative operand: resolves, not taken.
    drv(1, 3'd3, 1, 0, 32'hFFFF_FFFF, 32'd0, 32'h3000, 16'h0004, 0);
    cycle();
    chk("bgtz_rv", 32'(redirect_valid), 32'd0);
    chk("bgtz_res", 32'(resolved_cnt), 32'd2);
    chk("bgtz_taken", 32'(taken_cnt), 32'd1);
    idle(); cycle();

    // BNE waits three cycles for rt, then redirects backwards by one instruction.
    stalls = 0;
    drv(1, 3'd1, 1, 0, 32'd1, 32'd2, 32'h3000, 16'hFFFF, 0);
    for (int i = 0; i < 3; i++) begin cycle(); stalls += int'(last_stall); end
    b_ready = 1;
    cycle(); stalls += int'(last_stall);
    chk("bne_stalls", 32'(stalls), 32'd3);
    chk("bne_rv", 32'(redirect_valid), 32'd1);
    chk("bne_pc", redirect_pc, 32'h3000);
    idle(); cycle();

    // BLTZ stalled, flushed on the cycle rs arrives.
    drv(1, 3'd4, 0, 0, 32'hFFFF_FFF0, 32'd0, 32'h4000, 16'h0010, 0);
    cycle(); cycle();
    a_ready = 1; flush = 1;
    cycle();
    chk("flush_rv", 32'(redirect_valid), 32'd0);
    chk("flush_res", 32'(resolved_cnt), 32'd3);
    chk("flush_taken", 32'(taken_cnt), 32'd2);

    // Back in IDLE: BGEZ with wrapping target resolves straight away.
    drv(1, 3'd5, 1, 0, 32'd0, 32'd9, 32'hFFFF_FFFC, 16'h0000, 0);
    cycle();
    chk("wrap_rv", 32'(redirect_valid), 32'd1);
    chk("wrap_pc", redirect_pc, 32'h0000_0000);
    idle(); cycle();

    // Timeout: rt withheld for six stall cycles.
    chk("to_before", 32'(timeout), 32'd0);
    drv(1, 3'd0, 1, 0, 32'd7, 32'd7, 32'h5000, 16'h0001, 0);
    for (int i = 0; i < 5; i++) cycle();
    chk("to_at_limit", 32'(timeout), 32'd0);
    cycle();
    chk("to_set", 32'(timeout), 32'd1);
    b_ready = 1;
    cycle();
    chk("to_resolve_rv", 32'(redirect_valid), 32'd1);
    idle(); cycle();
    chk("to_sticky", 32'(timeout), 32'd1);
    do_reset();
    chk("to_cleared", 32'(timeout), 32'd0);
    cycle();

    // Reset while waiting discards the branch.
    drv(1, 3'd1, 1, 0, 32'd3, 32'd4, 32'h6000, 16'h0002, 0);
    cycle(); cycle();
    do_reset();
    idle();
    cycle(); cycle();
    chk("rst_wait_rv", 32'(redirect_valid), 32'd0);
    chk("rst_wait_res", 32'(resolved_cnt), 32'd0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] rs;
      rs = pick_val();
      drv($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
          $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
          rs, ($urandom_range(0, 1) == 1) ? rs : pick_val(),
          $urandom() & 32'hFFFF_FFFC, 16'($urandom()), $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
